// File: rtl/light_pkg.sv
// Shared light-level code meanings and ramp state encoding for the light FSM and dimmer.
package light_pkg;

  localparam logic [1:0] LIGHT_OFF  = 2'd0;
  localparam logic [1:0] LIGHT_LOW  = 2'd1;
  localparam logic [1:0] LIGHT_MID  = 2'd2;
  localparam logic [1:0] LIGHT_HIGH = 2'd3;

  typedef enum logic [1:0] {
    RAMP_IDLE = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

  // Step timer width; a divide-by-1 ramp still needs a 1-bit timer
  function automatic int unsigned timer_width(input int unsigned div);
    return (div > 1) ? int'($clog2(div)) : 1;
  endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM generator: free-running period counter, duty latched only at the period boundary.
module pwm_core #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_pwm
);

  localparam int unsigned         MAX      = (2 ** PWM_BITS) - 1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(MAX - 1);
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty_q;

  // Period of MAX cycles lets duty 0 stay low and duty MAX stay high
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt    <= '0;
      duty_q <= '0;
      o_pwm  <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt    <= '0;
        duty_q <= i_duty;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
      o_pwm <= (cnt < duty_q);
    end
  end

endmodule

// File: rtl/light_dimmer.sv
// LED dimmer: decodes the light level, ramps duty one LSB per RAMP_DIV cycles, drives PWM.
module light_dimmer
  import light_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned RAMP_DIV = 100000,
  parameter int unsigned LVL1     = 64,
  parameter int unsigned LVL2     = 160,
  parameter int unsigned LVL3     = 255
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [1:0]          i_light,
  output logic                o_pwm,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_busy
);

  localparam int unsigned         TIMER_W    = timer_width(RAMP_DIV);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(RAMP_DIV - 1);
  localparam logic [TIMER_W-1:0]  TIMER_ONE  = TIMER_W'(1);
  localparam logic [PWM_BITS-1:0] DUTY_ONE   = PWM_BITS'(1);

  logic [1:0]          r_light;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] cur_duty;
  logic [PWM_BITS-1:0] duty_d;
  logic [TIMER_W-1:0]  timer_q;
  logic [TIMER_W-1:0]  timer_d;
  ramp_state_t         state_q;
  ramp_state_t         state_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_light <= LIGHT_OFF;
    end else begin
      r_light <= i_light;
    end
  end

  always_comb begin
    target = '0;
    case (r_light)
      LIGHT_LOW:  target = PWM_BITS'(LVL1);
      LIGHT_MID:  target = PWM_BITS'(LVL2);
      LIGHT_HIGH: target = PWM_BITS'(LVL3);
      default:    target = '0;
    endcase
  end

  // Target is re-evaluated every cycle; a reversal restarts the step interval
  always_comb begin
    state_d = state_q;
    duty_d  = cur_duty;
    timer_d = timer_q;
    case (state_q)
      RAMP_IDLE: begin
        if (cur_duty < target) begin
          state_d = RAMP_UP;
          timer_d = '0;
        end else if (cur_duty > target) begin
          state_d = RAMP_DOWN;
          timer_d = '0;
        end
      end
      RAMP_UP: begin
        if (target == cur_duty) begin
          state_d = RAMP_IDLE;
          timer_d = '0;
        end else if (target < cur_duty) begin
          state_d = RAMP_DOWN;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          duty_d  = cur_duty + DUTY_ONE;
          timer_d = '0;
          if (duty_d == target) begin
            state_d = RAMP_IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      RAMP_DOWN: begin
        if (target == cur_duty) begin
          state_d = RAMP_IDLE;
          timer_d = '0;
        end else if (target > cur_duty) begin
          state_d = RAMP_UP;
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          duty_d  = cur_duty - DUTY_ONE;
          timer_d = '0;
          if (duty_d == target) begin
            state_d = RAMP_IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      default: begin
        state_d = RAMP_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= RAMP_IDLE;
      cur_duty <= '0;
      timer_q  <= '0;
      o_busy   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_duty <= duty_d;
      timer_q  <= timer_d;
      o_busy   <= (state_d != RAMP_IDLE);
    end
  end

  assign o_duty = cur_duty;

  pwm_core #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm_core (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_duty  (cur_duty),
    .o_pwm   (o_pwm)
  );

endmodule

// File: tb/tb_light_dimmer.sv
// Scoreboard bench for light_dimmer: expected duty/busy change events are queued, a monitor checks them.
module tb_light_dimmer;
  import light_pkg::*;

  localparam int unsigned PWM_BITS = 4;
  localparam int unsigned RAMP_DIV = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          light = LIGHT_OFF;
  logic                pwm;
  logic [PWM_BITS-1:0] duty;
  logic                busy;

  light_dimmer #(
    .PWM_BITS (PWM_BITS),
    .RAMP_DIV (RAMP_DIV),
    .LVL1     (4),
    .LVL2     (9),
    .LVL3     (15)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_light (light),
    .o_pwm   (pwm),
    .o_duty  (duty),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int duty;
    int busy;
    int at;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int d, input int b, input int at);
    exp_t e;
    e.duty = d;
    e.busy = b;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Busy rise at E1, then one step per RAMP_DIV cycles; only the first 'upto' steps are queued
  task automatic push_ramp(input int e0, input int from, input int to, input int upto);
    int n;
    int dir;
    n   = (to > from) ? (to - from) : (from - to);
    dir = (to > from) ? 1 : -1;
    expect_ev(from, 1, e0 + 1);
    for (int k = 1; k <= upto; k++) begin
      expect_ev(from + dir * k, (k == n) ? 0 : 1, e0 + 1 + int'(RAMP_DIV) * k);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_light(input logic [1:0] l, output int e0);
    e0    = cyc + 1;
    light = l;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: %0d events still pending after %0d cycles", name, sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic count_pwm(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      tick();
      highs += int'(pwm);
    end
  endtask

  // Monitor: every change of duty/busy must match the next queued event
  initial begin
    int   pd;
    int   pb;
    exp_t e;
    pd = 0;
    pb = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pd = int'(duty);
        pb = int'(busy);
      end else if (int'(duty) != pd || int'(busy) != pb) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_change: duty=%0d busy=%0d at cycle %0d, no change expected",
                   duty, busy, cyc);
        end else begin
          e = sb.pop_front();
          check("ev_duty", int'(duty), e.duty);
          check("ev_busy", int'(busy), e.busy);
          check("ev_cycle", cyc, e.at);
        end
        pd = int'(duty);
        pb = int'(busy);
      end
    end
  end

  initial begin
    int e0;
    int s;
    int h;
    int prev;
    int seen;
    bit found;

    // Asynchronous reset with no clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_pwm", int'(pwm), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_busy", int'(busy), 0);
    tick();
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (3) tick();

    // Ramp up 0 -> LVL1
    set_light(LIGHT_LOW, e0);
    push_ramp(e0, 0, 4, 4);
    drain("ramp_up", 40);
    repeat (17) tick();
    count_pwm(15, h);
    check("pwm_lvl1_highs", h, 4);

    // Full on, then off
    set_light(LIGHT_HIGH, e0);
    push_ramp(e0, 4, 15, 11);
    drain("ramp_full", 60);
    repeat (17) tick();
    count_pwm(15, h);
    check("pwm_full_highs", h, 15);
    set_light(LIGHT_OFF, e0);
    push_ramp(e0, 15, 0, 15);
    drain("ramp_off", 80);
    repeat (17) tick();
    count_pwm(15, h);
    check("pwm_off_highs", h, 0);
    check("duty_off", int'(duty), 0);

    // Reversal at duty 6 while heading for 9
    set_light(LIGHT_MID, e0);
    push_ramp(e0, 0, 9, 6);
    drain("rev_up", 40);
    s = cyc;
    check("rev_start_duty", int'(duty), 6);
    set_light(LIGHT_LOW, e0);
    expect_ev(5, 1, s + 6);
    expect_ev(4, 0, s + 10);
    drain("rev_down", 20);
    repeat (20) tick();
    check("rev_final_duty", int'(duty), 4);
    check("rev_final_busy", int'(busy), 0);

    // Target equals current mid-ramp
    set_light(LIGHT_OFF, e0);
    push_ramp(e0, 4, 0, 4);
    drain("eq_to_zero", 30);
    set_light(LIGHT_MID, e0);
    push_ramp(e0, 0, 9, 4);
    drain("eq_up", 30);
    s = cyc;
    set_light(LIGHT_LOW, e0);
    expect_ev(4, 0, s + 2);
    drain("eq_idle", 10);
    repeat (20) tick();
    check("eq_duty", int'(duty), 4);
    check("eq_busy", int'(busy), 0);

    // Glitch-free update: change level at cnt=7 of a duty-4 period
    found = 1'b0;
    prev  = int'(pwm);
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (pwm && prev == 0) found = 1'b1;
      prev = int'(pwm);
    end
    check("glitch_rise_found", int'(found), 1);
    h = 1;
    repeat (6) begin
      tick();
      h += int'(pwm);
    end
    set_light(LIGHT_HIGH, e0);
    push_ramp(e0, 4, 15, 11);
    repeat (8) begin
      tick();
      h += int'(pwm);
    end
    check("glitch_cur_period", h, 4);
    count_pwm(15, h);
    check("glitch_next_period", h, 5);
    drain("glitch_ramp", 60);

    // Asynchronous reset mid-ramp
    set_light(LIGHT_OFF, e0);
    push_ramp(e0, 15, 0, 2);
    drain("mid_ramp", 20);
    tick();
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    check("midrst_pwm", int'(pwm), 0);
    check("midrst_duty", int'(duty), 0);
    check("midrst_busy", int'(busy), 0);
    sb.delete();
    tick();
    tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    seen   = 0;
    repeat (20) begin
      tick();
      seen |= int'(busy);
    end
    check("post_rst_busy", seen, 0);
    check("post_rst_duty", int'(duty), 0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
